// File: rtl/rv_core_sequencer.sv
// Control sequencer for the single-cycle RV32I datapath: decode, boot, memory-wait
// stalling with timeout, halt/single-step debug control and a retired-instruction counter.
module rv_core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  lorbtype,
  input  logic [3:0]  alu_action,
  input  logic        zero,
  input  logic        run,
  input  logic        step_req,
  input  logic        mem_ready,
  output logic        PCsel1,
  output logic        PCsel0,
  output logic        enPC,
  output logic        ALUsrc,
  output logic        memtoreg1,
  output logic        memtoreg0,
  output logic        read_mem,
  output logic        write_mem,
  output logic        enW,
  output logic [2:0]  immsrc,
  output logic [4:0]  opr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StReset,
    StBoot,
    StExec,
    StMemWait,
    StHalt,
    StFault
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        step_q, step_d;
  logic [31:0] instret_q, instret_d;

  // Raw decode of the current opcode, independent of sequencer state.
  logic [1:0] dec_pc_sel;
  logic       dec_alu_src;
  logic [1:0] dec_mem_to_reg;
  logic       dec_read;
  logic       dec_write;
  logic       dec_en_w;
  logic [2:0] dec_imm;
  logic [4:0] dec_opr;
  logic       dec_mem;
  logic       dec_sys;
  logic       dec_ill;

  always_comb begin
    dec_pc_sel     = 2'b00;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 2'b00;
    dec_read       = 1'b0;
    dec_write      = 1'b0;
    dec_en_w       = 1'b0;
    dec_imm        = 3'b000;
    dec_opr        = 5'b00000;
    dec_mem        = 1'b0;
    dec_sys        = 1'b0;
    dec_ill        = 1'b0;
    unique case (opcode)
      OpR: begin
        dec_en_w = 1'b1;
        dec_opr  = {1'b0, alu_action};
      end
      OpIAlu: begin
        dec_alu_src = 1'b1;
        dec_en_w    = 1'b1;
        dec_opr     = {1'b0, alu_action};
      end
      OpLoad: begin
        dec_alu_src    = 1'b1;
        dec_read       = 1'b1;
        dec_mem_to_reg = 2'b01;
        dec_en_w       = 1'b1;
        dec_mem        = 1'b1;
      end
      OpStore: begin
        dec_alu_src = 1'b1;
        dec_imm     = 3'b001;
        dec_write   = 1'b1;
        dec_mem     = 1'b1;
      end
      OpBranch: begin
        dec_imm    = 3'b010;
        dec_pc_sel = zero ? 2'b01 : 2'b00;
        dec_opr    = {2'b10, lorbtype};
      end
      OpJal: begin
        dec_imm        = 3'b100;
        dec_pc_sel     = 2'b01;
        dec_mem_to_reg = 2'b11;
        dec_en_w       = 1'b1;
      end
      OpJalr: begin
        dec_alu_src    = 1'b1;
        dec_pc_sel     = 2'b10;
        dec_mem_to_reg = 2'b11;
        dec_en_w       = 1'b1;
      end
      OpLui: begin
        dec_alu_src = 1'b1;
        dec_imm     = 3'b011;
        dec_en_w    = 1'b1;
        dec_opr     = 5'b11111;
      end
      OpAuipc: begin
        dec_imm        = 3'b011;
        dec_mem_to_reg = 2'b10;
        dec_en_w       = 1'b1;
      end
      OpSystem: dec_sys = 1'b1;
      default:  dec_ill = 1'b1;
    endcase
  end

  logic [1:0] pc_sel;
  logic [1:0] mem_to_reg;
  logic       retire;

  // Memory instructions only commit (enW/enPC) on the cycle mem_ready is seen.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    step_d     = step_q;
    pc_sel     = 2'b00;
    mem_to_reg = 2'b00;
    enPC       = 1'b0;
    ALUsrc     = 1'b0;
    read_mem   = 1'b0;
    write_mem  = 1'b0;
    enW        = 1'b0;
    immsrc     = 3'b000;
    opr        = 5'b00000;
    retire     = 1'b0;

    unique case (state_q)
      StReset: state_d = StBoot;
      StBoot: begin
        pc_sel  = 2'b11;
        enPC    = 1'b1;
        state_d = run ? StExec : StHalt;
      end
      StExec: begin
        if (dec_ill) begin
          state_d = StFault;
        end else if (dec_sys) begin
          state_d = StHalt;
          step_d  = 1'b0;
        end else begin
          pc_sel     = dec_pc_sel;
          mem_to_reg = dec_mem_to_reg;
          ALUsrc     = dec_alu_src;
          read_mem   = dec_read;
          write_mem  = dec_write;
          immsrc     = dec_imm;
          opr        = dec_opr;
          if (dec_mem && !mem_ready) begin
            state_d    = StMemWait;
            wait_cnt_d = 8'd1;
          end else begin
            enPC   = 1'b1;
            enW    = dec_en_w;
            retire = 1'b1;
          end
        end
      end
      StMemWait: begin
        pc_sel     = dec_pc_sel;
        mem_to_reg = dec_mem_to_reg;
        ALUsrc     = dec_alu_src;
        read_mem   = dec_read;
        write_mem  = dec_write;
        immsrc     = dec_imm;
        opr        = dec_opr;
        if (mem_ready) begin
          enPC   = 1'b1;
          enW    = dec_en_w;
          retire = 1'b1;
        end else if (wait_cnt_q >= TimeoutCnt) begin
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StHalt: begin
        if (run) begin
          state_d = StExec;
        end else if (step_req) begin
          state_d = StExec;
          step_d  = 1'b1;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase

    // A single-stepped instruction always returns to HALT.
    if (retire) begin
      state_d = (run && !step_q) ? StExec : StHalt;
      step_d  = 1'b0;
    end
  end

  assign instret_d = instret_q + 32'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReset;
      wait_cnt_q <= 8'd0;
      step_q     <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      step_q     <= step_d;
      instret_q  <= instret_d;
    end
  end

  assign PCsel1    = pc_sel[1];
  assign PCsel0    = pc_sel[0];
  assign memtoreg1 = mem_to_reg[1];
  assign memtoreg0 = mem_to_reg[0];
  assign halted    = (state_q == StHalt);
  assign fault     = (state_q == StFault);
  assign instret   = instret_q;

endmodule

// File: tb/tb_rv_core_sequencer.sv
// Directed bench for rv_core_sequencer: decode vector table plus hand-written
// boot, memory-wait, halt/step, timeout and illegal-opcode sequences.
module tb_rv_core_sequencer;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  lorbtype;
  logic [3:0]  alu_action;
  logic        zero;
  logic        run;
  logic        step_req;
  logic        mem_ready;
  logic        PCsel1, PCsel0, enPC, ALUsrc, memtoreg1, memtoreg0;
  logic        read_mem, write_mem, enW;
  logic [2:0]  immsrc;
  logic [4:0]  opr;
  logic        halted, fault;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  rv_core_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .lorbtype   (lorbtype),
    .alu_action (alu_action),
    .zero       (zero),
    .run        (run),
    .step_req   (step_req),
    .mem_ready  (mem_ready),
    .PCsel1     (PCsel1),
    .PCsel0     (PCsel0),
    .enPC       (enPC),
    .ALUsrc     (ALUsrc),
    .memtoreg1  (memtoreg1),
    .memtoreg0  (memtoreg0),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .enW        (enW),
    .immsrc     (immsrc),
    .opr        (opr),
    .halted     (halted),
    .fault      (fault),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCsel[1:0], enPC, ALUsrc, memtoreg[1:0], read_mem, write_mem, enW, immsrc[2:0], opr[4:0]}
  logic [16:0] ctl;
  assign ctl = {PCsel1, PCsel0, enPC, ALUsrc, memtoreg1, memtoreg0,
                read_mem, write_mem, enW, immsrc, opr};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  lorb;
    logic [3:0]  alu;
    logic        z;
    logic [16:0] exp_ctl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               name     opcode      lorb    alu      z     pc en as m2r rd wr w imm    opr
    vecs[0]  = '{"addi",  7'b0010011, 3'd0, 4'b0000, 1'b0, {2'b00,1'b1,1'b1,2'b00,1'b0,1'b0,1'b1,3'b000,5'b00000}};
    vecs[1]  = '{"add",   7'b0110011, 3'd0, 4'b0101, 1'b0, {2'b00,1'b1,1'b0,2'b00,1'b0,1'b0,1'b1,3'b000,5'b00101}};
    vecs[2]  = '{"beq_t", 7'b1100011, 3'd0, 4'b0000, 1'b1, {2'b01,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,3'b010,5'b10000}};
    vecs[3]  = '{"bne_nt",7'b1100011, 3'd1, 4'b0000, 1'b0, {2'b00,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,3'b010,5'b10001}};
    vecs[4]  = '{"lw",    7'b0000011, 3'd2, 4'b0000, 1'b0, {2'b00,1'b1,1'b1,2'b01,1'b1,1'b0,1'b1,3'b000,5'b00000}};
    vecs[5]  = '{"sw",    7'b0100011, 3'd2, 4'b0000, 1'b0, {2'b00,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0,3'b001,5'b00000}};
    vecs[6]  = '{"jal",   7'b1101111, 3'd0, 4'b0000, 1'b0, {2'b01,1'b1,1'b0,2'b11,1'b0,1'b0,1'b1,3'b100,5'b00000}};
    vecs[7]  = '{"jalr",  7'b1100111, 3'd0, 4'b0000, 1'b0, {2'b10,1'b1,1'b1,2'b11,1'b0,1'b0,1'b1,3'b000,5'b00000}};
    vecs[8]  = '{"lui",   7'b0110111, 3'd0, 4'b0000, 1'b0, {2'b00,1'b1,1'b1,2'b00,1'b0,1'b0,1'b1,3'b011,5'b11111}};
    vecs[9]  = '{"auipc", 7'b0010111, 3'd0, 4'b0000, 1'b0, {2'b00,1'b1,1'b0,2'b10,1'b0,1'b0,1'b1,3'b011,5'b00000}};
    vecs[10] = '{"slti",  7'b0010011, 3'd0, 4'b1111, 1'b0, {2'b00,1'b1,1'b1,2'b00,1'b0,1'b0,1'b1,3'b000,5'b01111}};

    rst_n = 1'b0; run = 1'b1; step_req = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0010011; lorbtype = 3'd0; alu_action = 4'd0; zero = 1'b0;

    #12;
    chk("reset_ctl", 32'(ctl), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst_n = 1'b1;
    tick();  // BOOT
    @(negedge clk);
    chk("boot_ctl", 32'(ctl), 32'(17'b11_1_0_00_0_0_0_000_00000));
    tick();  // EXEC

    foreach (vecs[i]) begin
      opcode = vecs[i].op; lorbtype = vecs[i].lorb; alu_action = vecs[i].alu;
      zero = vecs[i].z; mem_ready = 1'b1;
      @(negedge clk);
      chk({vecs[i].name, "_ctl"}, 32'(ctl), 32'(vecs[i].exp_ctl));
      chk({vecs[i].name, "_instret"}, instret, 32'(i));
      tick();
    end
    chk("table_instret", instret, 32'd11);

    // Load stalled three cycles, completes on the fourth.
    opcode = 7'b0000011; zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      chk("ldw_read", 32'(read_mem), 32'd1);
      chk("ldw_enW", 32'(enW), 32'(k == 3));
      chk("ldw_enPC", 32'(enPC), 32'(k == 3));
      chk("ldw_instret", instret, 32'd11);
      tick();
    end
    chk("ldw_retired", instret, 32'd12);

    // ECALL with run low stops in HALT without retiring.
    run = 1'b0; mem_ready = 1'b1; opcode = 7'b1110011;
    @(negedge clk);
    chk("ecall_enPC", 32'(enPC), 32'd0);
    chk("ecall_enW", 32'(enW), 32'd0);
    tick();
    chk("ecall_halted", 32'(halted), 32'd1);
    chk("ecall_instret", instret, 32'd12);

    // Single step of a LUI.
    opcode = 7'b0110111; step_req = 1'b1;
    @(negedge clk);
    chk("halt_enW", 32'(enW), 32'd0);
    tick();
    step_req = 1'b0;
    @(negedge clk);
    chk("step_halted", 32'(halted), 32'd0);
    chk("step_enW", 32'(enW), 32'd1);
    chk("step_opr", 32'(opr), 32'b11111);
    tick();
    @(negedge clk);
    chk("step_back_halted", 32'(halted), 32'd1);
    chk("step_instret", instret, 32'd13);
    chk("step_halt_enPC", 32'(enPC), 32'd0);

    // Store never acknowledged: EXEC plus 15 wait cycles, then FAULT.
    run = 1'b1; opcode = 7'b0100011; mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("sto_write", 32'(write_mem), 32'd1);
      chk("sto_fault", 32'(fault), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_write", 32'(write_mem), 32'd0);
    chk("timeout_instret", instret, 32'd13);
    tick();
    chk("fault_sticky", 32'(fault), 32'd1);

    // Reset, boot with run low into HALT, then an illegal opcode faults.
    rst_n = 1'b0; run = 1'b0;
    #2;
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_instret", instret, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("boot_halted", 32'(halted), 32'd1);
    run = 1'b1; opcode = 7'b0000000; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ill_ctl", 32'(ctl), 32'd0);
    tick();
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_instret", instret, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_core_sequencer.md
# rv_core_sequencer

Sequencing controller for the single-cycle RV32I datapath. Drives every datapath control input (PC mux select, PC/register enables, ALU source and operation, immediate format, write-back select, memory strobes) from the decoded `opcode`/`lorbtype`/`alu_action`/`zero` outputs. Adds a boot step that loads the start address, memory-wait stalling with a timeout, halt/single-step control for debug, and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 15: maximum stall cycles waiting on `mem_ready` before faulting (1..255).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7, `lorbtype` input 3, `alu_action` input 4, `zero` input 1: from datapath.
- `run` input 1: level; 1 = free-run, 0 = stop at next instruction boundary.
- `step_req` input 1: one-cycle pulse; executes exactly one instruction while stopped.
- `mem_ready` input 1: data memory completed the current access.
- `PCsel1`, `PCsel0`, `enPC`, `ALUsrc`, `memtoreg1`, `memtoreg0`, `read_mem`, `write_mem`, `enW` output 1 each; `immsrc` output 3; `opr` output 5: datapath controls.
- `halted` output 1: in HALT state. `fault` output 1: in FAULT state (sticky until reset).
- `instret` output 32: retired-instruction count, wraps at 2^32.

## Operation
- States: RESET, BOOT, EXEC, MEMWAIT, HALT, FAULT. `rst_n`=0 forces RESET immediately.
- RESET -> BOOT on first edge after release. BOOT (1 cycle): PCsel=11 (initialize), enPC=1, all else 0 -> HALT if `run`=0 else EXEC.
- PCsel encoding: 00 PC+4, 01 PC+imm, 10 ALU result, 11 initialize. memtoreg: 00 ALU, 01 memory, 10 PC+imm, 11 PC+4. immsrc: 000 I, 001 S, 010 B, 011 U, 100 J.
- opr: R-type/I-ALU = {0,alu_action}; load/store/JALR/AUIPC = 00000 (add); branch = {10,lorbtype} (ALU sets `zero`=1 when condition holds); LUI = 11111 (pass operand B).
- Decode in EXEC (all unlisted outputs 0):
  - 0110011 R: ALUsrc=0, enW=1, memtoreg=00, PCsel=00.
  - 0010011 I-ALU: ALUsrc=1, immsrc=000, enW=1, memtoreg=00.
  - 0000011 load: ALUsrc=1, immsrc=000, read_mem=1, memtoreg=01; enW/enPC only when `mem_ready`.
  - 0100011 store: ALUsrc=1, immsrc=001, write_mem=1; enPC only when `mem_ready`.
  - 1100011 branch: ALUsrc=0, immsrc=010, PCsel = `zero` ? 01 : 00.
  - 1101111 JAL: immsrc=100, PCsel=01, memtoreg=11, enW=1. 1100111 JALR: ALUsrc=1, immsrc=000, PCsel=10, memtoreg=11, enW=1.
  - 0110111 LUI: ALUsrc=1, immsrc=011, enW=1, memtoreg=00. 0010111 AUIPC: immsrc=011, memtoreg=10, enW=1.
  - 1110011 (ECALL/EBREAK): no writes, enPC=0, -> HALT, not retired. Any other opcode: -> FAULT, no writes.
- Non-memory instructions: enPC=1 in EXEC, retire that edge.
- Load/store with `mem_ready`=0 in EXEC -> MEMWAIT; strobes and decode held; counter loads 1. MEMWAIT: on `mem_ready`=1 assert enPC (and enW for load), retire, leave; else increment; reaching MEM_TIMEOUT without ready -> FAULT, no writes.
- After retiring: `run`=1 -> EXEC, else HALT.
- HALT: all enables/strobes 0. `run`=1 -> EXEC. `step_req`=1 (with `run`=0) -> EXEC for one instruction, then back to HALT.
- FAULT: all enables/strobes 0; exits only via reset.
- `instret` increments by 1 on each retire edge.

## Timing
- Control outputs combinational from state + datapath inputs; state, wait counter, `instret`, step flag registered.
- Reset values: state RESET, all control outputs 0 (PCsel=00, immsrc=000, opr=00000), `halted`=0, `fault`=0, `instret`=0.
- Latency: non-memory 1 cycle/instruction; memory 1 + wait cycles.
- `run` deasserted mid-MEMWAIT: access completes and retires first, then HALT.
- `step_req` during EXEC/MEMWAIT or with `run`=1: ignored.
- Reset mid-MEMWAIT: strobes drop asynchronously; no partial write.

## Test plan
- Reset release, `run`=1, initialize=0x100 -> BOOT cycle with PCsel=11, enPC=1; next cycle EXEC, `instret`=0.
- ADDI/ADD/BEQ sequence, `zero`=1 on BEQ -> ALUsrc 1/0/0, opr 0_alu_action/0_alu_action/10000, PCsel 00/00/01; `instret`=3 after 3 cycles.
- Load with `mem_ready` low 3 cycles -> read_mem held 4 cycles, enW=enPC=1 only on 4th, `instret`+1.
- Store with `mem_ready` never high, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, `fault`=1, write_mem=0 thereafter.
- `run`=0 in HALT, `step_req` pulse on LUI -> one cycle EXEC with enW=1, opr=11111, back to HALT.
- Opcode 1110011 -> HALT, `halted`=1, enPC=0, `instret` unchanged; opcode 0000000 -> FAULT.
